instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch stage of the single-issue 9-bit-instruction core.
- Owns the program counter and drives a synchronous instruction ROM.
- Presents one registered instruction per cycle, with its PC, to the decode/ALU/lookup stage downstream.
- Handles stall, redirect on taken branch, and halt detection; halt drives the core's done output.

Parameters:
PC_W, 10, program counter / ROM address width
INSTR_W, 9, instruction width
START_ADDR, 0, PC value after reset and on start
HALT_INSTR, 9'h1FF, encoding that halts the core

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin fetching; sampled only in IDLE
stall  input  1  downstream cannot accept a new instruction this cycle
branch_taken  input  1  redirect the PC this cycle
branch_target  input  PC_W  redirect address, valid while branch_taken=1
imem_addr  output  PC_W  ROM address (combinational from the PC register)
imem_en  output  1  ROM read enable; ROM output register updates only when 1
imem_rdata  input  INSTR_W  ROM data, one cycle after the address is presented with imem_en=1
instr_o  output  INSTR_W  registered instruction to downstream
pc_o  output  PC_W  address of instr_o
instr_valid  output  1  instr_o/pc_o are a real instruction
done  output  1  sticky halt flag

Behaviour:
- States:
  - IDLE -> FETCH on start=1.
  - FETCH -> HALTED when the output register captures HALT_INSTR.
  - HALTED stays until reset.
  - start is ignored outside IDLE.
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=START_ADDR, f_valid=0.
  - instr_o=0, pc_o=0, instr_valid=0, done=0.
  - Takes effect immediately, mid-operation included; in-flight fetches are discarded.
- imem_addr=pc always; imem_en=1 only in FETCH with stall=0 (branch cycles included).
- Internal fetch tracking: f_valid and f_pc mark that imem_rdata holds the instruction at f_pc.
- advance = FETCH & ~stall. On an advance cycle with no branch:
  - pc<=pc+1, wrapping 2^PC_W-1 -> 0.
  - f_valid<=1, f_pc<=pc.
  - instr_o<=imem_rdata, pc_o<=f_pc, instr_valid<=f_valid.
- Stall (no branch): pc, f_valid, f_pc, instr_o, pc_o, instr_valid all hold; imem_en=0 so ROM data holds. No instruction is skipped or duplicated.
- Taken branch (FETCH, priority over stall):
  - pc<=branch_target, f_valid<=0, instr_valid<=0.
  - First target instruction reaches the outputs two edges after the redirect edge, giving exactly 2 bubble cycles.
- Halt: on an advance edge with f_valid=1, no branch and imem_rdata==HALT_INSTR:
  - Output captures it (instr_valid=1 for that cycle).
  - state<=HALTED, done<=1 on the same edge.
- HALTED:
  - imem_en=0, pc frozen.
  - instr_valid<=0 on the next edge; done held at 1 until reset.
- Halt and branch on the same edge: the branch wins, the halt is squashed, and done stays 0.
- Latency: start sampled at edge E0 -> first instruction (START_ADDR) valid after E2; thereafter one per cycle.
- IDLE: imem_en=0, instr_valid=0.

Test Plan:
- ROM[0..3]=001,002,003,004; reset then start at E0 -> after E2 instr_o=001/pc_o=0/valid=1, then 002,003,004 on consecutive cycles.
- Stall held 3 cycles while instr_o=002 -> instr_o/pc_o/valid hold and imem_en=0; after release, 003 then 004 with no gap, skip or duplicate.
- branch_taken with target 0x040 while pc_o=5 -> valid=0 for 2 cycles, then instr_o=ROM[0x040] with pc_o=0x040; branch together with stall behaves the same way.
- ROM[3]=1FF -> instr_o=1FF valid one cycle with done=1 from the same edge; then valid=0, imem_en=0, done stays 1 for 10 cycles; start pulse is ignored.
- START_ADDR=0x3FE -> pc_o sequence 0x3FE, 0x3FF, 0x000.
- reset pulled low between edges mid-stream -> instr_valid, done, pc_o and instr_o read 0 before the next edge; after release, start restarts from START_ADDR.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous ROM and presents
// one registered instruction per cycle with its PC; detects halt.
module instr_fetch #(
    parameter int unsigned               PC_W       = 10,
    parameter int unsigned               INSTR_W    = 9,
    parameter logic [PC_W-1:0]           START_ADDR = '0,
    parameter logic [INSTR_W-1:0]        HALT_INSTR = 9'h1FF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               instr_valid,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d, f_pc_q, f_pc_d, pc_o_q, pc_o_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 f_valid_q, f_valid_d, valid_q, valid_d, done_q, done_d;
    logic                 in_fetch, advance, redirect, halt_hit;

    assign in_fetch = (state_q == S_FETCH);
    assign redirect = in_fetch & branch_taken;
    assign advance  = in_fetch & ~stall;
    // A same-edge branch squashes the halt.
    assign halt_hit = advance & ~branch_taken & f_valid_q & (imem_rdata == HALT_INSTR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (halt_hit) state_d = S_HALTED;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // ROM output register only moves on advance, so its data survives stalls.
    always_comb begin
        imem_addr = pc_q;
        imem_en   = advance;
    end

    always_comb begin
        pc_d      = pc_q;
        f_pc_d    = f_pc_q;
        f_valid_d = f_valid_q;
        instr_d   = instr_q;
        pc_o_d    = pc_o_q;
        valid_d   = valid_q;
        done_d    = done_q | halt_hit;
        if (redirect) begin
            pc_d      = branch_target;
            f_valid_d = 1'b0;
            valid_d   = 1'b0;
        end else if (advance) begin
            pc_d      = pc_q + PC_W'(1);
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            instr_d   = imem_rdata;
            pc_o_d    = f_pc_q;
            valid_d   = f_valid_q;
        end else if (state_q == S_HALTED) begin
            valid_d   = 1'b0;
        end else if (state_q == S_IDLE && start) begin
            pc_d      = START_ADDR;
            f_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= START_ADDR;
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
            instr_q   <= '0;
            pc_o_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            instr_q   <= instr_d;
            pc_o_q    <= pc_o_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign instr_o     = instr_q;
    assign pc_o        = pc_o_q;
    assign instr_valid = valid_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table for the main stream, scoreboard under
// random stalls, and hand sequences for halt, squash, wrap and async reset.
module tb_instr_fetch;
    localparam int PC_W = 10;
    localparam int IW   = 9;

    logic            clk = 1'b0;
    logic            reset, start, stall, br;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] addr1, pc1, addr2, pc2;
    logic            en1, en2, v1, v2, d1, d2;
    logic [IW-1:0]   rd1, rd2, ins1, ins2;
    logic [IW-1:0]   rom [0:1023];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(IW), .START_ADDR(10'h000), .HALT_INSTR(9'h1FF)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr1), .imem_en(en1), .imem_rdata(rd1),
        .instr_o(ins1), .pc_o(pc1), .instr_valid(v1), .done(d1));

    instr_fetch #(.PC_W(PC_W), .INSTR_W(IW), .START_ADDR(10'h3FE), .HALT_INSTR(9'h1FF)) dut_wrap (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(br), .branch_target(tgt),
        .imem_addr(addr2), .imem_en(en2), .imem_rdata(rd2),
        .instr_o(ins2), .pc_o(pc2), .instr_valid(v2), .done(d2));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            if (en1) rd1 <= rom[addr1];
            if (en2) rd2 <= rom[addr2];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic st, input logic b, input logic [PC_W-1:0] t);
        @(negedge clk);
        start = s; stall = st; br = b; tgt = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;
        #1;
        chk({tag, "_valid"}, 32'(v1), 32'd0);
        chk({tag, "_done"},  32'(d1), 32'd0);
        chk({tag, "_pc"},    32'(pc1), 32'd0);
        chk({tag, "_instr"}, 32'(ins1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic            s, st, b;
        logic [PC_W-1:0] t;
        logic            en, v, dchk;
        logic [IW-1:0]   ins;
        logic [PC_W-1:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic st, input logic b, input logic [PC_W-1:0] t,
                                input logic en, input logic v, input logic dchk,
                                input logic [IW-1:0] ins, input logic [PC_W-1:0] pc);
        vec_t r;
        r.s = s; r.st = st; r.b = b; r.t = t;
        r.en = en; r.v = v; r.dchk = dchk; r.ins = ins; r.pc = pc;
        return r;
    endfunction

    typedef struct {
        logic [IW-1:0]   ins;
        logic [PC_W-1:0] pc;
    } exp_t;

    vec_t tv [19];
    exp_t sb_q [$];

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'(i + 1)};
        reset = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;
        #12;
        chk("rst_valid", 32'(v1), 32'd0);
        chk("rst_done",  32'(d1), 32'd0);
        chk("rst_en",    32'(en1), 32'd0);
        chk("rst_addr",  32'(addr1), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // s st b tgt | en v dchk instr pc
        tv[0]  = mk(1, 0, 0, 10'h000, 0, 0, 1, 9'h000, 10'h000);
        tv[1]  = mk(0, 0, 0, 10'h000, 1, 0, 1, 9'h000, 10'h000);
        tv[2]  = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h001, 10'h000);
        tv[3]  = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h002, 10'h001);
        tv[4]  = mk(0, 1, 0, 10'h000, 0, 1, 1, 9'h002, 10'h001);
        tv[5]  = mk(0, 1, 0, 10'h000, 0, 1, 1, 9'h002, 10'h001);
        tv[6]  = mk(0, 1, 0, 10'h000, 0, 1, 1, 9'h002, 10'h001);
        tv[7]  = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h003, 10'h002);
        tv[8]  = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h004, 10'h003);
        tv[9]  = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h005, 10'h004);
        tv[10] = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h006, 10'h005);
        tv[11] = mk(0, 0, 1, 10'h040, 1, 0, 0, 9'h000, 10'h000);
        tv[12] = mk(0, 0, 0, 10'h000, 1, 0, 0, 9'h000, 10'h000);
        tv[13] = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h041, 10'h040);
        tv[14] = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h042, 10'h041);
        tv[15] = mk(0, 1, 1, 10'h040, 0, 0, 0, 9'h000, 10'h000);
        tv[16] = mk(0, 0, 0, 10'h000, 1, 0, 0, 9'h000, 10'h000);
        tv[17] = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h041, 10'h040);
        tv[18] = mk(0, 0, 0, 10'h000, 1, 1, 1, 9'h042, 10'h041);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].s, tv[i].st, tv[i].b, tv[i].t);
            #1;
            chk($sformatf("v%0d_en", i), 32'(en1), 32'(tv[i].en));
            tick();
            chk($sformatf("v%0d_valid", i), 32'(v1), 32'(tv[i].v));
            chk($sformatf("v%0d_done", i), 32'(d1), 32'd0);
            if (tv[i].dchk) begin
                chk($sformatf("v%0d_instr", i), 32'(ins1), 32'(tv[i].ins));
                chk($sformatf("v%0d_pc", i), 32'(pc1), 32'(tv[i].pc));
            end
        end

        // Random stalls: every ROM word must come out once, in order.
        async_reset("rst0");
        drive(1, 0, 0, '0);
        for (int i = 0; i < 30; i++) begin
            exp_t e;
            e.ins = rom[i];
            e.pc  = PC_W'(i);
            sb_q.push_back(e);
        end
        tick();
        for (int c = 0; c < 300 && sb_q.size() > 0; c++) begin
            logic st;
            st = ($urandom_range(0, 2) == 0);
            drive(0, st, 0, '0);
            tick();
            if (!st && v1) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_instr", 32'(ins1), 32'(e.ins));
                chk("sb_pc",    32'(pc1),  32'(e.pc));
            end
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        async_reset("rst_mid");

        // Halt at ROM[3].
        rom[3] = 9'h1FF;
        drive(1, 0, 0, '0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, '0);
            tick();
            if (k == 4) chk("halt_pre_done", 32'(d1), 32'd0);
        end
        chk("halt_instr", 32'(ins1), 32'h1FF);
        chk("halt_pc",    32'(pc1),  32'd3);
        chk("halt_valid", 32'(v1),   32'd1);
        chk("halt_done",  32'(d1),   32'd1);
        for (int k = 0; k < 10; k++) begin
            drive((k == 3), 0, 0, '0);
            #1;
            chk("halted_en", 32'(en1), 32'd0);
            tick();
            chk("halted_valid", 32'(v1),    32'd0);
            chk("halted_done",  32'(d1),    32'd1);
            chk("halted_addr",  32'(addr1), 32'd5);
        end

        async_reset("rst_halt");

        // Branch on the halt edge squashes the halt.
        drive(1, 0, 0, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, '0);
            tick();
        end
        drive(0, 0, 1, 10'h010);
        tick();
        chk("sq_valid0", 32'(v1), 32'd0);
        chk("sq_done0",  32'(d1), 32'd0);
        drive(0, 0, 0, '0);
        tick();
        chk("sq_valid1", 32'(v1), 32'd0);
        drive(0, 0, 0, '0);
        tick();
        chk("sq_valid2", 32'(v1),   32'd1);
        chk("sq_instr",  32'(ins1), 32'h011);
        chk("sq_pc",     32'(pc1),  32'h010);
        chk("sq_done",   32'(d1),   32'd0);

        // PC wrap from a high start address.
        rom[3] = 9'h004;
        async_reset("rst_wrap");
        drive(1, 0, 0, '0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0, 0, '0);
            tick();
            if (k >= 2) begin
                chk("wrap_valid", 32'(v2), 32'd1);
                chk("wrap_pc", 32'(pc2), (k == 2) ? 32'h3FE : (k == 3) ? 32'h3FF : 32'h000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
